cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_capture_if.sv | 26 ++
 rtl/cam_capture.sv | 154 +++++++++++++++
 tb/tb_cam_capture.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_if.sv
// cam_capture_if -- bundles the camera-side inputs and the frame-buffer write
// port of cam_capture.
//   master : camera/host side; drives cam_vsync, cam_href, cam_data, capture_en
//            and consumes the frame-buffer write port and status.
//   slave  : the capture block; the mirror image of master.
interface cam_capture_if;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic        capture_en;
   logic        wr_en;
   logic [16:0] wr_addr;
   logic [15:0] wr_pixel;
   logic        frame_done;
   logic        capturing;

   modport master (
      output cam_vsync, cam_href, cam_data, capture_en,
      input  wr_en, wr_addr, wr_pixel, frame_done, capturing
   );

   modport slave (
      input  cam_vsync, cam_href, cam_data, capture_en,
      output wr_en, wr_addr, wr_pixel, frame_done, capturing
   );
endinterface

// File: rtl/cam_capture.sv
// cam_capture -- captures RGB565 camera frames, decimates 2:1 in both axes,
// reduces each pixel to 4:4:4 and emits frame-buffer writes.
// Ports:
//   clk_25MHz  sole clock, rising edge
//   rst        asynchronous active-high reset
//   bus        cam_capture_if.slave: camera vsync/href/data, capture_en in;
//              wr_en/wr_addr/wr_pixel, frame_done, capturing out
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset; waiting for vsync high
// S_VBLANK | vsync seen; waiting for vsync falling edge with capture_en
// S_ACTIVE | capturing a frame; ends on vsync rising edge
module cam_capture #(
   parameter int H_PIXELS  = 640,
   parameter int V_LINES   = 480,
   parameter int BUF_DEPTH = 76800
) (
   input  logic        clk_25MHz,
   input  logic        rst,
   cam_capture_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_VBLANK, S_ACTIVE} state_t;

   state_t      r_state;
   logic        r_vsync, r_vsync_d;
   logic        r_href, r_href_d;
   logic [7:0]  r_data;
   // Only the high-byte bits that survive the 4:4:4 reduction: {R[3:0], G[3:1]}
   logic [6:0]  r_hi;
   logic        r_phase;
   logic [15:0] r_col;
   logic [15:0] r_line;
   logic [16:0] r_wr_addr;
   logic        r_wr_en;
   logic [15:0] r_wr_pixel;
   logic        r_frame_done;
   logic        r_capturing;

   logic w_vs_rise, w_vs_fall, w_hr_rise, w_hr_fall, w_write_ok;

   assign w_vs_rise = r_vsync & ~r_vsync_d;
   assign w_vs_fall = ~r_vsync & r_vsync_d;
   assign w_hr_rise = r_href & ~r_href_d;
   assign w_hr_fall = ~r_href & r_href_d;

   // Evaluated with the column/line of the pixel being completed this cycle.
   assign w_write_ok = ~r_line[0] & ~r_col[0]
                     & ({16'd0, r_col} < 32'(H_PIXELS))
                     & ({16'd0, r_line} < 32'(V_LINES))
                     & ({15'd0, r_wr_addr} < 32'(BUF_DEPTH));

   always_ff @(posedge clk_25MHz or posedge rst) begin
      if (rst) begin
         r_vsync   <= 1'b0;
         r_vsync_d <= 1'b0;
         r_href    <= 1'b0;
         r_href_d  <= 1'b0;
         r_data    <= 8'h00;
      end else begin
         r_vsync   <= bus.cam_vsync;
         r_vsync_d <= r_vsync;
         r_href    <= bus.cam_href;
         r_href_d  <= r_href;
         r_data    <= bus.cam_data;
      end
   end

   always_ff @(posedge clk_25MHz or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_hi         <= 7'h00;
         r_phase      <= 1'b0;
         r_col        <= 16'h0000;
         r_line       <= 16'h0000;
         r_wr_addr    <= 17'h00000;
         r_wr_en      <= 1'b0;
         r_wr_pixel   <= 16'h0000;
         r_frame_done <= 1'b0;
         r_capturing  <= 1'b0;
      end else begin
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;
         // Writes are at least four cycles apart, so the address can trail
         // the strobe by one cycle without a second write seeing a stale value.
         if (r_wr_en) begin
            r_wr_addr <= r_wr_addr + 17'd1;
         end

         case (r_state)
            S_IDLE: begin
               if (r_vsync) begin
                  r_state <= S_VBLANK;
               end
            end

            S_VBLANK: begin
               if (w_vs_fall && bus.capture_en) begin
                  r_state     <= S_ACTIVE;
                  r_capturing <= 1'b1;
                  r_line      <= 16'h0000;
                  r_col       <= 16'h0000;
                  r_phase     <= 1'b0;
                  r_wr_addr   <= 17'h00000;
               end
            end

            S_ACTIVE: begin
               if (w_vs_rise) begin
                  // Abort: any half-assembled pixel is dropped here.
                  r_state      <= S_VBLANK;
                  r_capturing  <= 1'b0;
                  r_frame_done <= 1'b1;
                  r_phase      <= 1'b0;
               end else begin
                  if (w_hr_fall && r_line != 16'hFFFF) begin
                     r_line <= r_line + 16'd1;
                  end
                  if (r_href) begin
                     if (w_hr_rise || !r_phase) begin
                        r_hi    <= {r_data[7:4], r_data[2:0]};
                        r_phase <= 1'b1;
                        if (w_hr_rise) begin
                           r_col <= 16'h0000;
                        end
                     end else begin
                        r_phase <= 1'b0;
                        if (r_col != 16'hFFFF) begin
                           r_col <= r_col + 16'd1;
                        end
                        if (w_write_ok) begin
                           r_wr_en    <= 1'b1;
                           r_wr_pixel <= {4'h0, r_hi[6:3], r_hi[2:0], r_data[7], r_data[4:1]};
                        end
                     end
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.wr_en      = r_wr_en;
   assign bus.wr_addr    = r_wr_addr;
   assign bus.wr_pixel   = r_wr_pixel;
   assign bus.frame_done = r_frame_done;
   assign bus.capturing  = r_capturing;

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture -- directed bench for cam_capture. Two instances share the
// camera stimulus: dut_a (16x12, buffer 48 = full decimated frame) and dut_b
// (same geometry, buffer 40) so address saturation is seen independently of
// the line/column limits.
module tb_cam_capture;

   logic       clk_25MHz = 1'b0;
   logic       rst = 1'b1;
   logic       vsync = 1'b0;
   logic       href = 1'b0;
   logic       cen = 1'b0;
   logic [7:0] data = 8'h00;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;

   cam_capture_if if_a ();
   cam_capture_if if_b ();

   assign if_a.cam_vsync  = vsync;
   assign if_a.cam_href   = href;
   assign if_a.cam_data   = data;
   assign if_a.capture_en = cen;
   assign if_b.cam_vsync  = vsync;
   assign if_b.cam_href   = href;
   assign if_b.cam_data   = data;
   assign if_b.capture_en = cen;

   cam_capture #(.H_PIXELS(16), .V_LINES(12), .BUF_DEPTH(48)) dut_a (
      .clk_25MHz (clk_25MHz),
      .rst       (rst),
      .bus       (if_a.slave)
   );

   cam_capture #(.H_PIXELS(16), .V_LINES(12), .BUF_DEPTH(40)) dut_b (
      .clk_25MHz (clk_25MHz),
      .rst       (rst),
      .bus       (if_b.slave)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   always @(posedge clk_25MHz) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor / scoreboard
   logic [15:0] exp_pix = 16'h0000;
   int          exp_a = 0, exp_b = 0;
   int          wcnt_a = 0, wcnt_b = 0, fd_cnt = 0;
   int          last_addr_a = -1, cyc_wr_a = -100;
   logic [15:0] last_pix_a = 16'h0000;
   logic        cap_prev_a = 1'b0, cap_prev_b = 1'b0, fd_prev = 1'b0;

   always @(negedge clk_25MHz) begin
      if (rst) begin
         exp_a <= 0;
         exp_b <= 0;
      end else begin
         if (if_a.wr_en) begin
            check("wr_addr_a", {15'd0, if_a.wr_addr}, (if_a.capturing && !cap_prev_a) ? 0 : exp_a);
            check("wr_pixel_a", {16'd0, if_a.wr_pixel}, {16'd0, exp_pix});
            exp_a       <= exp_a + 1;
            wcnt_a      <= wcnt_a + 1;
            last_addr_a <= int'(if_a.wr_addr);
            last_pix_a  <= if_a.wr_pixel;
            cyc_wr_a    <= cyc;
         end else if (if_a.capturing && !cap_prev_a) begin
            exp_a <= 0;
         end
         if (if_b.wr_en) begin
            check("wr_addr_b", {15'd0, if_b.wr_addr}, exp_b);
            exp_b  <= exp_b + 1;
            wcnt_b <= wcnt_b + 1;
         end else if (if_b.capturing && !cap_prev_b) begin
            exp_b <= 0;
         end
         if (if_a.frame_done) begin
            check("fd_single_cycle", {31'd0, fd_prev}, 32'd0);
            fd_cnt <= fd_cnt + 1;
         end
      end
      cap_prev_a <= if_a.capturing;
      cap_prev_b <= if_b.capturing;
      fd_prev    <= if_a.frame_done;
   end

   task automatic drive(input logic v, input logic h, input logic [7:0] d);
      @(negedge clk_25MHz);
      vsync = v;
      href  = h;
      data  = d;
   endtask

   task automatic vs_high(input int n);
      repeat (n) drive(1'b1, 1'b0, 8'h00);
   endtask

   task automatic vs_low(input int n);
      repeat (n) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_line(input int npix, input logic [7:0] hi, input logic [7:0] lo);
      for (int i = 0; i < npix; i++) begin
         drive(1'b0, 1'b1, hi);
         drive(1'b0, 1'b1, lo);
      end
      repeat (4) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input int npix, input int nlines, input logic [7:0] hi, input logic [7:0] lo);
      for (int l = 0; l < nlines; l++) send_line(npix, hi, lo);
   endtask

   int wa0, wb0, fd0, cyc_low;

   initial begin
      // Reset values
      repeat (3) @(negedge clk_25MHz);
      #1;
      check("rst_wr_en", {31'd0, if_a.wr_en}, 0);
      check("rst_wr_addr", {15'd0, if_a.wr_addr}, 0);
      check("rst_wr_pixel", {16'd0, if_a.wr_pixel}, 0);
      check("rst_frame_done", {31'd0, if_a.frame_done}, 0);
      check("rst_capturing", {31'd0, if_a.capturing}, 0);
      @(negedge clk_25MHz);
      rst = 1'b0;

      // Full frame of 0xF81F -> 0x0F0F everywhere, one frame_done
      cen = 1'b1;
      vs_high(4);
      vs_low(4);
      check("t1_capturing", {31'd0, if_a.capturing}, 1);
      wa0 = wcnt_a; wb0 = wcnt_b; fd0 = fd_cnt;
      exp_pix = 16'h0F0F;
      send_frame(16, 12, 8'hF8, 8'h1F);
      vs_high(4);
      check("t1_writes_a", wcnt_a - wa0, 48);
      check("t1_last_addr_a", last_addr_a, 47);
      check("t1_writes_b", wcnt_b - wb0, 40);
      check("t1_addr_sat_b", {15'd0, if_b.wr_addr}, 40);
      check("t1_frame_done", fd_cnt - fd0, 1);
      check("t1_capturing_off", {31'd0, if_a.capturing}, 0);

      // Pixel packing, latency, odd trailing byte dropped on href rise
      vs_low(4);
      wa0 = wcnt_a;
      exp_pix = 16'h014A;
      drive(1'b0, 1'b1, 8'h12);
      drive(1'b0, 1'b1, 8'h34);
      cyc_low = cyc;
      drive(1'b0, 1'b1, 8'h56);
      drive(1'b0, 1'b1, 8'h78);
      drive(1'b0, 1'b1, 8'h9A);
      repeat (4) drive(1'b0, 1'b0, 8'h00);
      check("t2_writes_line0", wcnt_a - wa0, 1);
      check("t2_latency", cyc_wr_a - cyc_low, 2);
      check("t2_pixel", {16'd0, last_pix_a}, 32'h014A);
      send_line(1, 8'h00, 8'h00);
      exp_pix = 16'h0A76;
      send_line(1, 8'hAB, 8'hCD);
      check("t2_writes_line2", wcnt_a - wa0, 2);
      check("t2_pixel_realign", {16'd0, last_pix_a}, 32'h0A76);
      check("t2_addr_line2", last_addr_a, 1);
      vs_high(4);

      // capture_en low at vsync falling -> frame skipped
      cen = 1'b0;
      vs_low(4);
      wa0 = wcnt_a; fd0 = fd_cnt;
      check("t3_capturing", {31'd0, if_a.capturing}, 0);
      send_frame(4, 4, 8'hF8, 8'h1F);
      cen = 1'b1;
      send_line(4, 8'hF8, 8'h1F);
      vs_high(4);
      check("t3_writes", wcnt_a - wa0, 0);
      check("t3_frame_done", fd_cnt - fd0, 0);

      // capture_en dropped mid-frame does not stop the frame
      vs_low(4);
      wa0 = wcnt_a; fd0 = fd_cnt;
      exp_pix = 16'h0F0F;
      cen = 1'b0;
      send_frame(4, 3, 8'hF8, 8'h1F);
      vs_high(4);
      check("t4_writes", wcnt_a - wa0, 4);
      check("t4_frame_done", fd_cnt - fd0, 1);

      // Oversize frame: 20x14 clipped to 16x12, buffer cap on dut_b
      cen = 1'b1;
      vs_low(4);
      wa0 = wcnt_a; wb0 = wcnt_b; fd0 = fd_cnt;
      send_frame(20, 14, 8'hF8, 8'h1F);
      vs_high(4);
      check("t5_writes_a", wcnt_a - wa0, 48);
      check("t5_addr_a", {15'd0, if_a.wr_addr}, 48);
      check("t5_writes_b", wcnt_b - wb0, 40);
      check("t5_addr_sat_b", {15'd0, if_b.wr_addr}, 40);
      check("t5_frame_done", fd_cnt - fd0, 1);

      // vsync rises at byte 3 of line 10: line aborted
      vs_low(4);
      wa0 = wcnt_a; fd0 = fd_cnt;
      send_frame(4, 10, 8'hF8, 8'h1F);
      exp_pix = 16'h014A;
      drive(1'b0, 1'b1, 8'h12);
      drive(1'b0, 1'b1, 8'h34);
      drive(1'b1, 1'b1, 8'h56);
      drive(1'b1, 1'b1, 8'h78);
      drive(1'b1, 1'b1, 8'h56);
      drive(1'b1, 1'b1, 8'h78);
      vs_high(4);
      check("t6_writes", wcnt_a - wa0, 11);
      check("t6_frame_done", fd_cnt - fd0, 1);
      vs_low(4);
      wa0 = wcnt_a;
      exp_pix = 16'h0F0F;
      send_line(2, 8'hF8, 8'h1F);
      check("t6_next_writes", wcnt_a - wa0, 1);
      check("t6_next_addr", last_addr_a, 0);

      // Reset mid-frame
      send_frame(2, 3, 8'hF8, 8'h1F);
      drive(1'b0, 1'b1, 8'hF8);
      drive(1'b0, 1'b1, 8'h1F);
      @(negedge clk_25MHz);
      rst = 1'b1;
      #1;
      check("t7_rst_wr_en", {31'd0, if_a.wr_en}, 0);
      check("t7_rst_wr_addr", {15'd0, if_a.wr_addr}, 0);
      check("t7_rst_wr_pixel", {16'd0, if_a.wr_pixel}, 0);
      check("t7_rst_frame_done", {31'd0, if_a.frame_done}, 0);
      check("t7_rst_capturing", {31'd0, if_a.capturing}, 0);
      drive(1'b0, 1'b1, 8'hF8);
      drive(1'b0, 1'b1, 8'h1F);
      rst = 1'b0;
      wa0 = wcnt_a; fd0 = fd_cnt;
      send_frame(4, 2, 8'hF8, 8'h1F);
      check("t7_no_writes", wcnt_a - wa0, 0);
      check("t7_capturing", {31'd0, if_a.capturing}, 0);
      vs_high(4);
      check("t7_no_frame_done", fd_cnt - fd0, 0);
      vs_low(4);
      send_line(2, 8'hF8, 8'h1F);
      check("t7_resume_writes", wcnt_a - wa0, 1);
      check("t7_resume_addr", last_addr_a, 0);
      vs_high(4);
      check("t7_frame_done", fd_cnt - fd0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
